// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared definitions for the shared instruction/data memory arbiter:
//   FSM state encoding, requester port ids and default bus widths.
//   Optional feature macro used by the arbiter: MEM_ARB_DBG_PORT_EN.
package mem_arb_pkg;

   localparam int unsigned ADDR_W_DEF    = 8;
   localparam int unsigned DATA_W_DEF    = 32;
   localparam int unsigned WDATA_W_DEF   = 8;
   localparam int unsigned MEM_DEPTH_DEF = 128;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StAccess = 2'd1,
      StResp   = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      PORT_IF  = 2'd0,
      PORT_DM  = 2'd1,
      PORT_DBG = 2'd2
   } port_e;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// mem_arb_rr_pick
//   Combinational two-way round-robin pick between instruction fetch and
//   data access. On a tie the port that did not own the last tie wins.
// Ports
//   reqs        in   2  request vector, [0] = IF, [1] = DM
//   last_owner  in   2  port id that won the previous tie
//   winner      out  2  port id of the selected requester (PORT_IF when idle)
//   any         out  1  at least one request pending
module mem_arb_rr_pick
   import mem_arb_pkg::*;
(
   input  logic [1:0] reqs,
   input  logic [1:0] last_owner,
   output logic [1:0] winner,
   output logic       any
);

   always_comb begin
      any    = |reqs;
      winner = PORT_IF;
      if (reqs == 2'b11) begin
         winner = (last_owner == PORT_IF) ? PORT_DM : PORT_IF;
      end else if (reqs[1]) begin
         winner = PORT_DM;
      end
   end

endmodule

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter
//   Sequences the single shared 128x32 instruction/data memory. Instruction
//   fetch (read-only) and data access (read / byte write) are arbitrated
//   round-robin; each access takes IDLE/RESP -> ACCESS -> RESP, so a read
//   requested in cycle N is granted in N+1 and returns data in N+2.
//   Out-of-range addresses are still granted; writes are suppressed and
//   reads return zero.
//   Define MEM_ARB_DBG_PORT_EN to add a debug port with strict priority over
//   IF and DM; it never changes the round-robin history.
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   if_req/if_addr                fetch request and address
//   if_gnt/if_rvalid/if_rdata     fetch grant pulse, data-valid pulse, data
//   dm_req/dm_we/dm_addr/dm_wdata data request, write flag, address, byte
//   dm_gnt/dm_rvalid/dm_rdata     data grant pulse, read-valid pulse, data
//   dbg_*                         debug port (MEM_ARB_DBG_PORT_EN only)
//   mem_addr/mem_wdata/mem_we     memory address, write byte, write enable
//   mem_rdata                     memory combinational read data
module mem_access_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W    = ADDR_W_DEF,
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned WDATA_W   = WDATA_W_DEF,
   parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               if_req,
   input  logic [ADDR_W-1:0]  if_addr,
   output logic               if_gnt,
   output logic               if_rvalid,
   output logic [DATA_W-1:0]  if_rdata,
   input  logic               dm_req,
   input  logic               dm_we,
   input  logic [ADDR_W-1:0]  dm_addr,
   input  logic [WDATA_W-1:0] dm_wdata,
   output logic               dm_gnt,
   output logic               dm_rvalid,
   output logic [DATA_W-1:0]  dm_rdata,
`ifdef MEM_ARB_DBG_PORT_EN
   input  logic               dbg_req,
   input  logic               dbg_we,
   input  logic [ADDR_W-1:0]  dbg_addr,
   input  logic [WDATA_W-1:0] dbg_wdata,
   output logic               dbg_gnt,
   output logic               dbg_rvalid,
   output logic [DATA_W-1:0]  dbg_rdata,
`endif
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [WDATA_W-1:0] mem_wdata,
   output logic               mem_we,
   input  logic [DATA_W-1:0]  mem_rdata
);

   localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(MEM_DEPTH);

   state_e             state_q;
   port_e              owner_q;
   port_e              last_owner_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [WDATA_W-1:0] wdata_q;
   logic               we_q;
   logic               in_range_q;

   logic [1:0]         rr_winner;
   logic               rr_any;
   port_e              pick_id;
   logic               pick_any;
   logic               pick_tie;
   logic [ADDR_W-1:0]  sel_addr;
   logic [WDATA_W-1:0] sel_wdata;
   logic               sel_we;
   logic               sel_in_range;
   logic [DATA_W-1:0]  rd_word;
   logic               in_access;

   mem_arb_rr_pick u_rr_pick (
      .reqs       ({dm_req, if_req}),
      .last_owner (last_owner_q),
      .winner     (rr_winner),
      .any        (rr_any)
   );

   // Final pick: debug (if present) overrides the round-robin result.
   always_comb begin
      pick_any  = rr_any;
      pick_id   = port_e'(rr_winner);
      pick_tie  = if_req & dm_req;
`ifdef MEM_ARB_DBG_PORT_EN
      if (dbg_req) begin
         pick_any = 1'b1;
         pick_id  = PORT_DBG;
         pick_tie = 1'b0;
      end
`endif
      sel_addr  = if_addr;
      sel_wdata = '0;
      sel_we    = 1'b0;
      unique case (pick_id)
         PORT_DM: begin
            sel_addr  = dm_addr;
            sel_wdata = dm_wdata;
            sel_we    = dm_we;
         end
`ifdef MEM_ARB_DBG_PORT_EN
         PORT_DBG: begin
            sel_addr  = dbg_addr;
            sel_wdata = dbg_wdata;
            sel_we    = dbg_we;
         end
`endif
         default: ;
      endcase
      sel_in_range = ({1'b0, sel_addr} < DepthLim);
   end

   // Memory pins are driven from the latched access only while in ACCESS.
   always_comb begin
      in_access = (state_q == StAccess);
      mem_addr  = in_access ? addr_q  : '0;
      mem_wdata = in_access ? wdata_q : '0;
      mem_we    = in_access & we_q & in_range_q;
      rd_word   = in_range_q ? mem_rdata : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         owner_q      <= PORT_IF;
         last_owner_q <= PORT_DM;
         addr_q       <= '0;
         wdata_q      <= '0;
         we_q         <= 1'b0;
         in_range_q   <= 1'b0;
         if_gnt       <= 1'b0;
         if_rvalid    <= 1'b0;
         if_rdata     <= '0;
         dm_gnt       <= 1'b0;
         dm_rvalid    <= 1'b0;
         dm_rdata     <= '0;
`ifdef MEM_ARB_DBG_PORT_EN
         dbg_gnt      <= 1'b0;
         dbg_rvalid   <= 1'b0;
         dbg_rdata    <= '0;
`endif
      end else begin
         if_gnt    <= 1'b0;
         if_rvalid <= 1'b0;
         dm_gnt    <= 1'b0;
         dm_rvalid <= 1'b0;
`ifdef MEM_ARB_DBG_PORT_EN
         dbg_gnt    <= 1'b0;
         dbg_rvalid <= 1'b0;
`endif
         unique case (state_q)
            // RESP samples requests exactly like IDLE, giving back-to-back accesses.
            StIdle, StResp: begin
               if (pick_any) begin
                  state_q    <= StAccess;
                  owner_q    <= pick_id;
                  addr_q     <= sel_addr;
                  wdata_q    <= sel_wdata;
                  we_q       <= sel_we;
                  in_range_q <= sel_in_range;
                  if (pick_tie) begin
                     last_owner_q <= pick_id;
                  end
                  // gnt is high exactly during the ACCESS cycle.
                  unique case (pick_id)
                     PORT_IF: if_gnt <= 1'b1;
                     PORT_DM: dm_gnt <= 1'b1;
`ifdef MEM_ARB_DBG_PORT_EN
                     PORT_DBG: dbg_gnt <= 1'b1;
`endif
                     default: ;
                  endcase
               end else begin
                  state_q <= StIdle;
               end
            end
            StAccess: begin
               state_q <= StResp;
               if (!we_q) begin
                  unique case (owner_q)
                     PORT_IF: begin
                        if_rvalid <= 1'b1;
                        if_rdata  <= rd_word;
                     end
                     PORT_DM: begin
                        dm_rvalid <= 1'b1;
                        dm_rdata  <= rd_word;
                     end
`ifdef MEM_ARB_DBG_PORT_EN
                     PORT_DBG: begin
                        dbg_rvalid <= 1'b1;
                        dbg_rdata  <= rd_word;
                     end
`endif
                     default: ;
                  endcase
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
